// File: rtl/seg_pkg.sv
// Shared state encoding, frame snapshot type, hex segment table and
// leading-zero helper for the seven-segment scan controller.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_e;

    typedef struct packed {
        logic [15:0] digit_val;
        logic [3:0]  dp;
        logic [3:0]  blank_mask;
        logic        lz_en;
    } snapshot_t;

    // Active-high g..a patterns, entry i is hex digit i.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [3:0] lz_dark_mask(input logic [15:0] val, input logic lz_en);
        logic [3:0] m;
        m[3] = lz_en && (val[15:12] == 4'h0);
        m[2] = m[3]  && (val[11:8]  == 4'h0);
        m[1] = m[2]  && (val[7:4]   == 4'h0);
        m[0] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/seg_decode.sv
// Hex nibble plus decimal point to an active-high 8-bit segment pattern.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] pattern
);

    assign pattern = {dp, HEX_SEG[nibble]};

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller with blank gaps between slots,
// per-frame input snapshots and leading-zero suppression.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int CLK_DIV   = 27000,
    parameter int BLANK_CYC = 270,
    parameter bit DIG_ACT   = 1'b1,
    parameter bit SEG_ACT   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] digit_val,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_mask,
    input  logic        lz_en,
    output logic [3:0]  dig,
    output logic [7:0]  smg,
    output logic        frame_done
);

    localparam int SHOW_CYC = CLK_DIV - BLANK_CYC;
    localparam int CNT_W    = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [3:0] DIG_OFF = {4{~DIG_ACT}};
    localparam logic [7:0] SEG_OFF = {8{~SEG_ACT}};

    scan_state_e      state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [1:0]       sel, sel_nx;
    snapshot_t        snap, snap_nx, live;
    logic             frame_nx;
    logic [3:0]       nibble_nx;
    logic [3:0]       lz_dark_nx;
    logic             lit_nx;
    logic [7:0]       pattern_nx;
    logic [3:0]       dig_nx;
    logic [7:0]       smg_nx;

    assign live = {digit_val, dp_in, blank_mask, lz_en};

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        sel_nx   = sel;
        snap_nx  = snap;
        frame_nx = 1'b0;
        if (!en) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            sel_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = SHOW;
                    cnt_nx   = '0;
                    sel_nx   = '0;
                    snap_nx  = live;
                end
                SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        state_nx = BLANK;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CNT_ONE;
                    end
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_nx = SHOW;
                        cnt_nx   = '0;
                        sel_nx   = sel + 2'd1;
                        // Frame boundary: new values are taken only here.
                        if (sel == 2'd3) begin
                            frame_nx = 1'b1;
                            snap_nx  = live;
                        end
                    end else begin
                        cnt_nx = cnt + CNT_ONE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Outputs are computed from next-state values so they register together with the state.
    always_comb begin
        nibble_nx = '0;
        case (sel_nx)
            2'd0: nibble_nx = snap_nx.digit_val[3:0];
            2'd1: nibble_nx = snap_nx.digit_val[7:4];
            2'd2: nibble_nx = snap_nx.digit_val[11:8];
            2'd3: nibble_nx = snap_nx.digit_val[15:12];
            default: nibble_nx = '0;
        endcase
    end

    seg_decode u_decode (
        .nibble  (nibble_nx),
        .dp      (snap_nx.dp[sel_nx]),
        .pattern (pattern_nx)
    );

    always_comb begin
        lz_dark_nx = lz_dark_mask(snap_nx.digit_val, snap_nx.lz_en);
        lit_nx     = (state_nx == SHOW) && !snap_nx.blank_mask[sel_nx] && !lz_dark_nx[sel_nx];
        dig_nx     = DIG_OFF;
        smg_nx     = SEG_OFF;
        if (lit_nx) begin
            dig_nx = (4'b0001 << sel_nx) ^ DIG_OFF;
            smg_nx = pattern_nx ^ SEG_OFF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sel        <= '0;
            snap       <= '0;
            dig        <= DIG_OFF;
            smg        <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            sel        <= sel_nx;
            snap       <= snap_nx;
            dig        <= dig_nx;
            smg        <= smg_nx;
            frame_done <= frame_nx;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with an 8-cycle slot (6 show + 2 blank),
// active-high digits and active-low segments.
module tb_seg_scan_ctrl;

    localparam int CLK_DIV   = 8;
    localparam int BLANK_CYC = 2;
    localparam int SHOW_CYC  = CLK_DIV - BLANK_CYC;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] digit_val;
    logic [3:0]  dp_in;
    logic [3:0]  blank_mask;
    logic        lz_en;
    logic [3:0]  dig;
    logic [7:0]  smg;
    logic        frame_done;

    int num_vec;
    int num_bad;

    // Expected per-digit lit flags and segment bytes (digit i at [8i+7:8i]).
    typedef struct {
        logic [15:0] val;
        logic [3:0]  dp;
        logic [3:0]  mask;
        logic        lz;
        logic [3:0]  lit;
        logic [31:0] smgs;
    } vec_t;

    vec_t vecs[6];
    vec_t v1234, v0000, v0007;

    seg_scan_ctrl #(
        .CLK_DIV   (CLK_DIV),
        .BLANK_CYC (BLANK_CYC),
        .DIG_ACT   (1'b1),
        .SEG_ACT   (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .digit_val  (digit_val),
        .dp_in      (dp_in),
        .blank_mask (blank_mask),
        .lz_en      (lz_en),
        .dig        (dig),
        .smg        (smg),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input int k, input logic [3:0] ed,
                                input logic [7:0] es, input logic ef);
        num_vec++;
        if (dig !== ed || smg !== es || frame_done !== ef) begin
            num_bad++;
            $display("[TB] FAIL %s k=%0d dig=%b exp=%b smg=%h exp=%h frame_done=%b exp=%b",
                     tag, k, dig, ed, smg, es, frame_done, ef);
        end
    endtask

    task automatic check_cycle(input string tag, input vec_t v, input int k, input logic ef);
        int slot;
        int pos;
        logic [3:0] ed;
        logic [7:0] es;
        slot = (k / CLK_DIV) % 4;
        pos  = k % CLK_DIV;
        ed   = 4'b0000;
        es   = 8'hFF;
        if (pos < SHOW_CYC && v.lit[slot]) begin
            ed = 4'b0001 << slot;
            es = v.smgs[slot*8 +: 8];
        end
        check_output(tag, k, ed, es, ef);
    endtask

    task automatic apply_stimulus(input vec_t v);
        digit_val  = v.val;
        dp_in      = v.dp;
        blank_mask = v.mask;
        lz_en      = v.lz;
    endtask

    // Return to IDLE, load the inputs, then let the next edge start a frame (k=0).
    task automatic start_frame(input vec_t v);
        en = 1'b0;
        tick();
        apply_stimulus(v);
        en = 1'b1;
        tick();
    endtask

    initial begin
        num_vec    = 0;
        num_bad    = 0;
        rst        = 1'b1;
        en         = 1'b0;
        digit_val  = 16'h0000;
        dp_in      = 4'h0;
        blank_mask = 4'h0;
        lz_en      = 1'b0;

        vecs[0] = '{16'h1234, 4'b0000, 4'b0000, 1'b0, 4'b1111, 32'hF9A4B099};
        vecs[1] = '{16'h0007, 4'b0000, 4'b0000, 1'b1, 4'b0001, 32'hFFFFFFF8};
        vecs[2] = '{16'h8888, 4'b0001, 4'b0100, 1'b0, 4'b1011, 32'h80FF8000};
        vecs[3] = '{16'h0000, 4'b0000, 4'b0000, 1'b0, 4'b1111, 32'hC0C0C0C0};
        vecs[4] = '{16'h0A0F, 4'b0000, 4'b0000, 1'b1, 4'b0111, 32'hFF88C08E};
        vecs[5] = '{16'h0000, 4'b1111, 4'b0000, 1'b1, 4'b0001, 32'hFFFFFF40};
        v1234 = vecs[0];
        v0007 = vecs[1];
        v0000 = vecs[3];

        #1;
        check_output("reset_init", 0, 4'b0000, 8'hFF, 1'b0);

        // Async reset in the middle of a SHOW slot.
        apply_stimulus(v1234);
        en = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        check_cycle("pre_reset_show", v1234, 2, 1'b0);
        rst = 1'b1;
        #1;
        check_output("reset_async", 0, 4'b0000, 8'hFF, 1'b0);
        en = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("reset_en_low", i, 4'b0000, 8'hFF, 1'b0);
        end

        // Full frames from the vector table, including the frame_done edge.
        for (int n = 0; n < 6; n++) begin
            start_frame(vecs[n]);
            for (int k = 0; k < 4 * CLK_DIV; k++) begin
                check_cycle($sformatf("table%0d", n), vecs[n], k, 1'b0);
                tick();
            end
            check_cycle($sformatf("table%0d_wrap", n), vecs[n], 0, 1'b1);
            tick();
            check_cycle($sformatf("table%0d_after", n), vecs[n], 1, 1'b0);
        end

        // Input change mid-frame stays invisible until the next frame.
        start_frame(v1234);
        for (int k = 0; k < 4 * CLK_DIV; k++) begin
            check_cycle("midframe", v1234, k, 1'b0);
            if (k == 10) digit_val = 16'h0000;
            tick();
        end
        check_cycle("midframe_new", v0000, 0, 1'b1);
        for (int k = 1; k < CLK_DIV + 2; k++) begin
            tick();
            check_cycle("midframe_new", v0000, k, 1'b0);
        end

        // Drop en during the BLANK of digit 2, then restart with fresh values.
        start_frame(v1234);
        for (int k = 0; k < 2 * CLK_DIV + SHOW_CYC + 1; k++) begin
            check_cycle("drop_pre", v1234, k, 1'b0);
            tick();
        end
        en = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            check_output("drop_idle", i, 4'b0000, 8'hFF, 1'b0);
        end
        apply_stimulus(v0007);
        en = 1'b1;
        for (int k = 0; k < 2 * CLK_DIV; k++) begin
            tick();
            check_cycle("restart", v0007, k, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", num_vec, num_bad);
        $finish;
    end

endmodule
